// File: rtl/axis_acq_pkg.sv
// Shared definitions for the acquisition sequencer: the FSM state encoding,
// also decoded by the status registers.
package axis_acq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RST   = 3'd1,
      ST_ARMED = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } acq_state_t;

endpackage

// File: rtl/axis_acq_if.sv
// AXI4-Stream bundle (data, valid, ready) used for both the ADC side and the
// RAM-writer side of the sequencer.
interface axis_acq_if #(
   parameter int W = 32
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_acq_trig_edge.sv
// Rising-edge detector for the external trigger; edges are masked while the
// sequencer is still pulsing reset_ram.
module axis_acq_trig_edge (
   input  logic aclk,
   input  logic areset,
   input  logic trig,
   input  logic clr,
   output logic trig_rise
);

   logic trig_d;

   // trig_d keeps tracking trig during clr, so a level held through RST
   // never looks like a fresh edge once ARMED.
   always_ff @(posedge aclk) begin
      if (areset) trig_d <= 1'b0;
      else        trig_d <= trig;
   end

   assign trig_rise = trig & ~trig_d & ~clr;

endmodule

// File: rtl/axis_acq_sequencer.sv
// Gates one ADC burst into the RAM writer: arm, pulse reset_ram, wait for a
// trigger edge, pass cfg_samples beats (or run continuously), then stop.
module axis_acq_sequencer
   import axis_acq_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 32,
   parameter int RST_CYCLES       = 4
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cfg_arm,
   input  logic                  cfg_continuous,
   input  logic [CNTR_WIDTH-1:0] cfg_samples,
   input  logic                  trig,
   axis_acq_if.slave             s_axis,
   axis_acq_if.master            m_axis,
   output logic                  reset_ram,
   output logic [2:0]            sts_state,
   output logic [CNTR_WIDTH-1:0] sts_count,
   output logic                  sts_stall
);

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

   acq_state_t                  st;
   logic [RCW-1:0]              rst_cnt;
   logic [CNTR_WIDTH-1:0]       samples_q;
   logic                        cont_q;
   logic                        trig_rise;
   logic                        run;
   logic                        beat;
   logic [CNTR_WIDTH-1:0]       cnt_inc;
   logic [AXIS_TDATA_WIDTH-1:0] pass_data;

   axis_acq_trig_edge u_trig (
      .aclk      (aclk),
      .areset    (areset),
      .trig      (trig),
      .clr       (st == ST_RST),
      .trig_rise (trig_rise)
   );

   // Zero-latency pass-through in RUN; otherwise drain the source.
   assign run           = (st == ST_RUN) && !areset;
   assign pass_data     = s_axis.tdata;
   assign m_axis.tdata  = pass_data;
   assign m_axis.tvalid = run & s_axis.tvalid;
   assign s_axis.tready = run ? m_axis.tready : 1'b1;
   assign beat          = run & s_axis.tvalid & m_axis.tready;
   assign cnt_inc       = sts_count + CNTR_WIDTH'(1);

   assign reset_ram = areset || (st == ST_RST);
   assign sts_state = st;

   always_ff @(posedge aclk) begin
      if (areset) begin
         st        <= ST_IDLE;
         rst_cnt   <= '0;
         samples_q <= '0;
         cont_q    <= 1'b0;
         sts_count <= '0;
         sts_stall <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (cfg_arm && (cfg_continuous || cfg_samples != '0)) begin
                  st        <= ST_RST;
                  rst_cnt   <= '0;
                  samples_q <= cfg_samples;
                  cont_q    <= cfg_continuous;
                  sts_count <= '0;
                  sts_stall <= 1'b0;
               end
            end
            ST_RST: begin
               if (!cfg_arm)                st      <= ST_IDLE;
               else if (rst_cnt == RST_LAST) st      <= ST_ARMED;
               else                          rst_cnt <= rst_cnt + RCW'(1);
            end
            ST_ARMED: begin
               if (!cfg_arm)       st <= ST_IDLE;
               else if (trig_rise) st <= ST_RUN;
            end
            ST_RUN: begin
               // A beat in the abort cycle is still transferred, so count it.
               if (beat) sts_count <= cnt_inc;
               if (s_axis.tvalid && !m_axis.tready) sts_stall <= 1'b1;
               if (!cfg_arm)                                  st <= ST_IDLE;
               else if (beat && !cont_q && cnt_inc == samples_q) st <= ST_DONE;
            end
            ST_DONE: begin
               if (!cfg_arm) st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule
